// File: rtl/floo_pkg.sv
// Shared constants and index types for the HBM request scheduler.
package floo_pkg;

    localparam int unsigned NumReqDefault         = 32'd4;
    localparam int unsigned MaxOutstandingDefault = 32'd8;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

    localparam int unsigned SrcIdxWidth = idx_width(NumReqDefault);
    localparam int unsigned CntWidth    = $clog2(MaxOutstandingDefault) + 32'd1;

    typedef logic [SrcIdxWidth-1:0] src_idx_t;

endpackage

// File: rtl/fifo_v3.sv
// Source-index FIFO: power-of-two depth, extra pointer bit separates full from empty.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32'd2,
    parameter int unsigned DEPTH      = 32'd8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);
    localparam int unsigned AddrW = $clog2(DEPTH);

    logic [AddrW:0]          r_wptr;
    logic [AddrW:0]          r_rptr;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic                    w_push;
    logic                    w_pop;

    assign empty_o = (r_wptr == r_rptr);
    assign full_o  = (r_wptr[AddrW] != r_rptr[AddrW]) &&
                     (r_wptr[AddrW-1:0] == r_rptr[AddrW-1:0]);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign data_o  = r_mem[r_rptr[AddrW-1:0]];

    // Read/write pointers, wrapping naturally through the extra MSB.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + {{AddrW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rptr <= r_rptr + {{AddrW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage needs no reset: stale entries are unreachable while empty.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr[AddrW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/floo_hbm_req_scheduler_chk.sv
// Protocol checker for the scheduler, observing its ports only.
module floo_hbm_req_scheduler_chk #(
    parameter int unsigned NumReq         = 32'd4,
    parameter int unsigned PayloadWidth   = 32'd64,
    parameter int unsigned MaxOutstanding = 32'd8
) (
    input logic                                clk_i,
    input logic                                rst_i,
    input logic [NumReq-1:0]                   req_ready_o,
    input logic                                hbm_req_valid_o,
    input logic                                hbm_req_ready_i,
    input logic [PayloadWidth-1:0]             hbm_req_data_o,
    input logic [$clog2(NumReq)-1:0]           hbm_req_src_o,
    input logic                                hbm_rsp_valid_i,
    input logic                                hbm_rsp_ready_o,
    input logic [NumReq-1:0]                   rsp_valid_o,
    input logic [$clog2(MaxOutstanding):0]     outstanding_o,
    input logic                                busy_o
);
    localparam int unsigned CntW = $clog2(MaxOutstanding) + 32'd1;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        outstanding_o <= CntW'(MaxOutstanding))
        else $error("outstanding count overflow");

    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !busy_o |-> !hbm_rsp_ready_o)
        else $error("response accepted with nothing outstanding");

    a_rsp_when_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        hbm_rsp_valid_i |-> busy_o)
        else $error("response beat with nothing outstanding");

    a_grant_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(req_ready_o) && $onehot0(rsp_valid_o))
        else $error("grant or route not one-hot");

    a_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        hbm_req_valid_o && !hbm_req_ready_i |=>
        hbm_req_valid_o && $stable(hbm_req_src_o) && $stable(hbm_req_data_o))
        else $error("request changed under backpressure");

endmodule

// File: rtl/floo_hbm_req_scheduler.sv
// Round-robin scheduler sharing one HBM port among requesters; responses return
// in order and are routed back using a FIFO of granted source indices.
module floo_hbm_req_scheduler
    import floo_pkg::*;
#(
    parameter int unsigned NumReq         = NumReqDefault,
    parameter int unsigned PayloadWidth   = 32'd64,
    parameter int unsigned RspWidth       = 32'd64,
    parameter int unsigned MaxOutstanding = MaxOutstandingDefault
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NumReq-1:0]                      req_valid_i,
    output logic [NumReq-1:0]                      req_ready_o,
    input  logic [NumReq-1:0][PayloadWidth-1:0]    req_data_i,
    output logic                                   hbm_req_valid_o,
    input  logic                                   hbm_req_ready_i,
    output logic [PayloadWidth-1:0]                hbm_req_data_o,
    output logic [$clog2(NumReq)-1:0]              hbm_req_src_o,
    input  logic                                   hbm_rsp_valid_i,
    output logic                                   hbm_rsp_ready_o,
    input  logic [RspWidth-1:0]                    hbm_rsp_data_i,
    input  logic                                   hbm_rsp_last_i,
    output logic [NumReq-1:0]                      rsp_valid_o,
    input  logic [NumReq-1:0]                      rsp_ready_i,
    output logic [RspWidth-1:0]                    rsp_data_o,
    output logic                                   rsp_last_o,
    output logic [$clog2(MaxOutstanding):0]        outstanding_o,
    output logic                                   busy_o
);
    localparam int unsigned SrcW = $clog2(NumReq);
    localparam int unsigned CntW = $clog2(MaxOutstanding) + 32'd1;

    logic [SrcW-1:0] r_ptr;
    logic            r_lock;
    logic [SrcW-1:0] r_lock_idx;
    logic [CntW-1:0] r_cnt;

    logic [SrcW-1:0] w_grant;
    logic [SrcW:0]   w_sum;
    logic            w_any;
    logic            w_full;
    logic            w_req_hs;
    logic            w_rsp_en;
    logic            w_rsp_pop;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [SrcW-1:0] w_head;
    logic            w_rst_n;

    // Round-robin pick starting at r_ptr; a pending stalled grant overrides it.
    always_comb begin
        w_grant = r_ptr;
        w_any   = 1'b0;
        w_sum   = '0;
        if (r_lock) begin
            w_grant = r_lock_idx;
            w_any   = req_valid_i[r_lock_idx];
        end else begin
            for (int k = int'(NumReq) - 1; k >= 0; k--) begin
                w_sum = {1'b0, r_ptr} + (SrcW+1)'(k);
                if (w_sum >= (SrcW+1)'(NumReq)) begin
                    w_sum = w_sum - (SrcW+1)'(NumReq);
                end else begin
                    w_sum = w_sum;
                end
                if (req_valid_i[w_sum[SrcW-1:0]]) begin
                    w_grant = w_sum[SrcW-1:0];
                    w_any   = 1'b1;
                end else begin
                    w_any   = w_any;
                end
            end
        end
    end

    assign w_full          = (r_cnt == CntW'(MaxOutstanding)) || w_fifo_full;
    assign hbm_req_valid_o = !rst_i && w_any && !w_full;
    assign hbm_req_data_o  = req_data_i[w_grant];
    assign hbm_req_src_o   = w_grant;
    assign w_req_hs        = hbm_req_valid_o && hbm_req_ready_i;

    // Only the granted requester sees the downstream ready.
    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            req_ready_o[i] = hbm_req_valid_o && hbm_req_ready_i && (w_grant == SrcW'(i));
        end
    end

    assign w_rsp_en        = !rst_i && !w_fifo_empty;
    assign hbm_rsp_ready_o = w_rsp_en && rsp_ready_i[w_head];
    assign rsp_data_o      = hbm_rsp_data_i;
    assign rsp_last_o      = hbm_rsp_last_i;
    assign w_rsp_pop       = hbm_rsp_valid_i && hbm_rsp_ready_o && hbm_rsp_last_i;

    // Response beats steer to the oldest outstanding source.
    always_comb begin
        rsp_valid_o = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            rsp_valid_o[i] = w_rsp_en && hbm_rsp_valid_i && (w_head == SrcW'(i));
        end
    end

    assign outstanding_o = r_cnt;
    assign busy_o        = (r_cnt != '0);
    assign w_rst_n       = !rst_i;

    // Pointer, lock and in-flight counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr      <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_req_hs) begin
                r_ptr  <= (w_grant == SrcW'(NumReq - 32'd1)) ? '0 : w_grant + SrcW'(1);
                r_lock <= 1'b0;
            end else if (hbm_req_valid_o) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_grant;
            end else begin
                r_lock <= r_lock;
            end
            case ({w_req_hs, w_rsp_pop})
                2'b10:   r_cnt <= r_cnt + CntW'(1);
                2'b01:   r_cnt <= r_cnt - CntW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    fifo_v3 #(
        .DATA_WIDTH (SrcW),
        .DEPTH      (MaxOutstanding)
    ) i_src_fifo (
        .clk_i   (clk_i),
        .rst_ni  (w_rst_n),
        .flush_i (1'b0),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .data_i  (w_grant),
        .push_i  (w_req_hs),
        .data_o  (w_head),
        .pop_i   (w_rsp_pop)
    );

endmodule

// File: tb/tb_floo_hbm_req_scheduler.sv
// Scoreboard bench: expected grants queued at stimulus, routes modelled in order.
module tb_floo_hbm_req_scheduler;
    import floo_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [3:0]        req_valid_i;
    logic [3:0]        req_ready_o;
    logic [3:0][63:0]  req_data_i;
    logic              hbm_req_valid_o;
    logic              hbm_req_ready_i;
    logic [63:0]       hbm_req_data_o;
    logic [1:0]        hbm_req_src_o;
    logic              hbm_rsp_valid_i;
    logic              hbm_rsp_ready_o;
    logic [63:0]       hbm_rsp_data_i;
    logic              hbm_rsp_last_i;
    logic [3:0]        rsp_valid_o;
    logic [3:0]        rsp_ready_i;
    logic [63:0]       rsp_data_o;
    logic              rsp_last_o;
    logic [3:0]        outstanding_o;
    logic              busy_o;

    int       n_vec = 0;
    int       n_err = 0;
    int       exp_q[$];
    src_idx_t route_q[$];

    always #5 clk_i = ~clk_i;

    floo_hbm_req_scheduler #(
        .NumReq(4), .PayloadWidth(64), .RspWidth(64), .MaxOutstanding(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
        .hbm_req_valid_o(hbm_req_valid_o), .hbm_req_ready_i(hbm_req_ready_i),
        .hbm_req_data_o(hbm_req_data_o), .hbm_req_src_o(hbm_req_src_o),
        .hbm_rsp_valid_i(hbm_rsp_valid_i), .hbm_rsp_ready_o(hbm_rsp_ready_o),
        .hbm_rsp_data_i(hbm_rsp_data_i), .hbm_rsp_last_i(hbm_rsp_last_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_last_o(rsp_last_o),
        .outstanding_o(outstanding_o), .busy_o(busy_o)
    );

    floo_hbm_req_scheduler_chk #(
        .NumReq(4), .PayloadWidth(64), .MaxOutstanding(8)
    ) u_chk (
        .clk_i(clk_i), .rst_i(rst_i), .req_ready_o(req_ready_o),
        .hbm_req_valid_o(hbm_req_valid_o), .hbm_req_ready_i(hbm_req_ready_i),
        .hbm_req_data_o(hbm_req_data_o), .hbm_req_src_o(hbm_req_src_o),
        .hbm_rsp_valid_i(hbm_rsp_valid_i), .hbm_rsp_ready_o(hbm_rsp_ready_o),
        .rsp_valid_o(rsp_valid_o), .outstanding_o(outstanding_o), .busy_o(busy_o)
    );

    function automatic logic [63:0] data_of(input int i);
        return 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h0000_0101_0000_0011;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: compare against the model, then advance to the next negedge.
    task automatic tick();
        int       e;
        src_idx_t r;
        bit       rsp_hs;
        #1;
        check("outstanding", 64'(outstanding_o), 64'(route_q.size()));
        check("busy", 64'(busy_o), 64'(route_q.size() != 0));
        rsp_hs = 1'b0;
        r      = '0;
        if (hbm_rsp_valid_i) begin
            r = route_q[0];
            check("rsp_route", 64'(rsp_valid_o), 64'(4'b0001 << r));
            check("rsp_ready", 64'(hbm_rsp_ready_o), 64'(rsp_ready_i[r]));
            check("rsp_data", rsp_data_o, hbm_rsp_data_i);
            rsp_hs = rsp_ready_i[r] && hbm_rsp_last_i;
        end
        if (hbm_req_valid_o && hbm_req_ready_i) begin
            if (exp_q.size() == 0) begin
                check("grant_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("grant_src", 64'(hbm_req_src_o), 64'(e));
                check("grant_data", hbm_req_data_o, data_of(e));
                check("grant_ready", 64'(req_ready_o), 64'(4'b0001 << e));
                route_q.push_back(src_idx_t'(e));
            end
        end
        if (rsp_hs) begin
            void'(route_q.pop_front());
        end
        @(negedge clk_i);
    endtask

    // Return beats until every outstanding request has seen its last beat.
    task automatic drain(input int beats, input bit rand_ready);
        int  b     = 0;
        int  guard = 0;
        bit  hs;
        while (route_q.size() != 0 && guard < 400) begin
            hbm_rsp_valid_i = 1'b1;
            hbm_rsp_last_i  = (b == beats - 1);
            hbm_rsp_data_i  = {$urandom, $urandom};
            rsp_ready_i     = rand_ready ? 4'($urandom) : 4'hF;
            hs              = rsp_ready_i[route_q[0]];
            tick();
            if (hs) b = (b == beats - 1) ? 0 : b + 1;
            guard++;
        end
        hbm_rsp_valid_i = 1'b0;
        hbm_rsp_last_i  = 1'b0;
        check("drain_done", 64'(route_q.size()), 64'd0);
    endtask

    initial begin
        rst_i           = 1'b1;
        req_valid_i     = 4'hF;
        hbm_req_ready_i = 1'b1;
        hbm_rsp_valid_i = 1'b0;
        hbm_rsp_data_i  = 64'd0;
        hbm_rsp_last_i  = 1'b0;
        rsp_ready_i     = 4'hF;
        for (int i = 0; i < 4; i++) req_data_i[i] = data_of(i);

        @(negedge clk_i);
        #1;
        check("rst_hbm_valid", 64'(hbm_req_valid_o), 64'd0);
        check("rst_req_ready", 64'(req_ready_o), 64'd0);
        check("rst_outstanding", 64'(outstanding_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Continuous requests from everyone: strict rotation 0,1,2,3,0.
        foreach (exp_q[i]) exp_q.delete();
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        for (int c = 0; c < 5; c++) tick();
        req_valid_i = 4'h0;
        tick();
        check("rr_all_granted", 64'(exp_q.size()), 64'd0);
        drain(1, 1'b0);

        // Stalled grant to 2 holds while 0 and 3 arrive; 3 follows on release.
        req_valid_i     = 4'b0100;
        hbm_req_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) req_valid_i = 4'b1101;
            #1;
            check("hold_valid", 64'(hbm_req_valid_o), 64'd1);
            check("hold_src", 64'(hbm_req_src_o), 64'd2);
            check("hold_ready", 64'(req_ready_o), 64'd0);
            tick();
        end
        hbm_req_ready_i = 1'b1;
        exp_q.push_back(2);
        tick();
        req_valid_i = 4'b1001;
        exp_q.push_back(3);
        tick();
        req_valid_i = 4'b0001;
        exp_q.push_back(0);
        tick();
        req_valid_i = 4'b0000;
        tick();
        check("hold_all_granted", 64'(exp_q.size()), 64'd0);
        drain(1, 1'b0);

        // Fill to the limit, ninth request waits for one completion.
        req_valid_i = 4'b0010;
        for (int c = 0; c < 8; c++) exp_q.push_back(1);
        for (int c = 0; c < 8; c++) tick();
        for (int c = 0; c < 2; c++) begin
            #1;
            check("full_valid", 64'(hbm_req_valid_o), 64'd0);
            check("full_ready", 64'(req_ready_o), 64'd0);
            tick();
        end
        hbm_rsp_valid_i = 1'b1;
        hbm_rsp_last_i  = 1'b1;
        rsp_ready_i     = 4'hF;
        tick();
        hbm_rsp_valid_i = 1'b0;
        hbm_rsp_last_i  = 1'b0;
        exp_q.push_back(1);
        tick();
        req_valid_i = 4'b0000;
        tick();
        check("full_all_granted", 64'(exp_q.size()), 64'd0);
        drain(1, 1'b1);

        // Bursts of four beats routed 1,3,1 with random downstream backpressure.
        req_valid_i = 4'b0010; exp_q.push_back(1); tick();
        req_valid_i = 4'b1000; exp_q.push_back(3); tick();
        req_valid_i = 4'b0010; exp_q.push_back(1); tick();
        req_valid_i = 4'b0000; tick();
        drain(4, 1'b1);

        // Request and last-beat handshakes in the same cycle at three outstanding.
        req_valid_i = 4'b0001; exp_q.push_back(0); tick();
        req_valid_i = 4'b0100; exp_q.push_back(2); tick();
        req_valid_i = 4'b1000; exp_q.push_back(3); tick();
        req_valid_i     = 4'b0010;
        exp_q.push_back(1);
        hbm_rsp_valid_i = 1'b1;
        hbm_rsp_last_i  = 1'b1;
        rsp_ready_i     = 4'hF;
        tick();
        hbm_rsp_valid_i = 1'b0;
        hbm_rsp_last_i  = 1'b0;
        req_valid_i     = 4'b0000;
        tick();
        check("simul_count", 64'(outstanding_o), 64'd3);
        drain(1, 1'b0);

        // Reset mid-burst with five outstanding.
        req_valid_i = 4'hF;
        for (int c = 0; c < 5; c++) exp_q.push_back((2 + c) % 4);
        for (int c = 0; c < 5; c++) tick();
        req_valid_i     = 4'b1010;
        hbm_req_ready_i = 1'b0;
        hbm_rsp_valid_i = 1'b1;
        hbm_rsp_last_i  = 1'b0;
        tick();
        #1;
        rst_i = 1'b1;
        #1;
        check("arst_hbm_valid", 64'(hbm_req_valid_o), 64'd0);
        check("arst_req_ready", 64'(req_ready_o), 64'd0);
        check("arst_rsp_ready", 64'(hbm_rsp_ready_o), 64'd0);
        check("arst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("arst_outstanding", 64'(outstanding_o), 64'd0);
        check("arst_busy", 64'(busy_o), 64'd0);
        route_q.delete();
        exp_q.delete();
        hbm_rsp_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i           = 1'b0;
        hbm_req_ready_i = 1'b1;
        exp_q.push_back(1);
        tick();
        req_valid_i = 4'b0000;
        tick();
        check("post_rst_granted", 64'(exp_q.size()), 64'd0);
        drain(1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
